// File: rtl/fuzzy_sched_pkg.sv
// Shared types and constants for the fuzzy-zone scheduler.
package fuzzy_sched_pkg;

  // Job sequencing states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Result reported to a zone whose job timed out.
  localparam logic [7:0] G_TIMEOUT = 8'h00;

  // Width of a zone index; never narrower than one bit.
  function automatic int idx_width(input int n_zones);
    return (n_zones > 1) ? $clog2(n_zones) : 1;
  endfunction

endpackage

// File: rtl/fuzzy_zone_scheduler_if.sv
// Zone-side request/grant bus plus the handshake towards the fuzzy core.
interface fuzzy_zone_scheduler_if #(
  parameter int N_ZONES = 4
);

  logic [N_ZONES-1:0]   req;
  logic [8*N_ZONES-1:0] T_in;
  logic [8*N_ZONES-1:0] dT_in;
  logic [N_ZONES-1:0]   gnt;
  logic [N_ZONES-1:0]   done;
  logic [N_ZONES-1:0]   err;
  logic [7:0]           G_res;

  logic                 core_start;
  logic [7:0]           core_T;
  logic [7:0]           core_dT;
  logic                 core_busy;
  logic                 core_valid;
  logic [7:0]           core_G;

  // Scheduler view.
  modport slave (
    input  req, T_in, dT_in, core_busy, core_valid, core_G,
    output gnt, done, err, G_res, core_start, core_T, core_dT
  );

  // Environment view: the zones and the fuzzy core.
  modport master (
    output req, T_in, dT_in, core_busy, core_valid, core_G,
    input  gnt, done, err, G_res, core_start, core_T, core_dT
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr,
// wrapping from N_ZONES-1 back to 0.
module rr_arbiter #(
  parameter int N_ZONES = 4,
  parameter int IW      = 2
) (
  input  logic [N_ZONES-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [N_ZONES-1:0] gnt_onehot,
  output logic [IW-1:0]      idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Zone index ptr+k, wrapped into 0..N_ZONES-1 (ptr is always in range).
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_ZONES) s = s - N_ZONES;
    return IW'(s);
  endfunction

  // Walk the zones in priority order and keep the first one requesting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    gnt_onehot = '0;
    idx        = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < N_ZONES; k++) begin
      cand = wrap_idx(ptr, k);
      if (!found && req[cand]) begin
        found            = 1'b1;
        idx              = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fuzzy_zone_scheduler.sv
// Shares one fuzzy core among N_ZONES requesters: round-robin capture of a
// zone's operands, one start pulse, bounded wait for the result, then a
// done (result) or err (timeout) pulse back to the served zone.
module fuzzy_zone_scheduler
  import fuzzy_sched_pkg::*;
#(
  parameter int N_ZONES = 4,
  parameter int TMO_CYC = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  fuzzy_zone_scheduler_if.slave  bus
);

  localparam int IW = idx_width(N_ZONES);
  localparam int CW = $clog2(TMO_CYC + 1);
  // Counter value seen in the TMO_CYC-th WAIT cycle; the counter reaches
  // TMO_CYC at the end of that cycle.
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(N_ZONES - 1);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        tmo_cnt;
  logic [IW-1:0]        arb_idx;
  logic [N_ZONES-1:0]   arb_gnt;

  rr_arbiter #(
    .N_ZONES (N_ZONES),
    .IW      (IW)
  ) u_rr_arbiter (
    .req        (bus.req),
    .ptr        (ptr),
    .gnt_onehot (arb_gnt),
    .idx        (arb_idx)
  );

  // Job sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this block holds only control and output flops (no memory
      // arrays), so all of it is cleared; a reset mid-job drops the job
      // without a done or err pulse.
      state          <= S_IDLE;
      ptr            <= '0;
      idx            <= '0;
      tmo_cnt        <= '0;
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.err        <= '0;
      bus.core_start <= 1'b0;
      bus.G_res      <= '0;
      bus.core_T     <= '0;
      bus.core_dT    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below sees the value from before this edge.
      bus.done       <= '0;
      bus.err        <= '0;
      bus.core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            idx            <= arb_idx;
            bus.gnt        <= arb_gnt;
            bus.core_T     <= bus.T_in[8*arb_idx +: 8];
            bus.core_dT    <= bus.dT_in[8*arb_idx +: 8];
            bus.core_start <= 1'b1;
            state          <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A result in the last allowed cycle still counts as success.
          if (bus.core_valid) begin
            bus.G_res     <= bus.core_G;
            bus.done[idx] <= 1'b1;
            state         <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.G_res     <= G_TIMEOUT;
            bus.err[idx]  <= 1'b1;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          bus.gnt <= '0;
          ptr     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzy_zone_scheduler.sv
// Self-checking bench for fuzzy_zone_scheduler: the bench plays both the
// zones and the fuzzy core, and predicts each job from its transaction-level
// timeline (capture, launch, v wait cycles or timeout, response, idle).
module tb_fuzzy_zone_scheduler;

  localparam int N   = 4;
  localparam int TMO = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fuzzy_zone_scheduler_if #(.N_ZONES(N)) bus ();

  fuzzy_zone_scheduler #(
    .N_ZONES (N),
    .TMO_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ptr_m    = 0;      // zone with highest priority next
  logic [7:0] gres_m   = 8'h00;  // last reported result

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requesting zone at or after p, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_outputs(input string tag, input logic [N-1:0] eg,
                               input logic [N-1:0] ed, input logic [N-1:0] ee,
                               input logic es);
    check({tag, ".gnt"},        bus.gnt,        eg);
    check({tag, ".done"},       bus.done,       ed);
    check({tag, ".err"},        bus.err,        ee);
    check({tag, ".core_start"}, bus.core_start, es);
    check({tag, ".G_res"},      bus.G_res,      gres_m);
  endtask

  task automatic check_reset_state(input string tag);
    check_outputs(tag, '0, '0, '0, 1'b0);
    check({tag, ".core_T"},  bus.core_T,  8'h00);
    check({tag, ".core_dT"}, bus.core_dT, 8'h00);
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    bus.req        = '0;
    bus.core_valid = 1'b0;
    repeat (n) @(negedge clk);
    gres_m = 8'h00;
    check_reset_state("reset");
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  // No requests: everything stays quiet; a stray core_valid is ignored.
  task automatic idle(input int n);
    bus.req = '0;
    repeat (n) begin
      bus.core_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_outputs("idle_quiet", '0, '0, '0, 1'b0);
    end
    bus.core_valid = 1'b0;
  endtask

  // One complete job. Called at a negedge with the DUT idle; returns at the
  // negedge of the idle cycle that follows the response.
  //   v     : core_valid is pulsed in the v-th wait cycle (v > TMO: never)
  //   spur  : stray core_valid during the idle and launch cycles
  //   scram : replace req/T_in/dT_in right after capture
  task automatic run_job(input logic [N-1:0] r, input logic [8*N-1:0] t,
                         input logic [8*N-1:0] dt, input int v, input logic [7:0] g,
                         input bit spur, input bit scram, input logic [N-1:0] r2,
                         input logic [8*N-1:0] t2, input logic [8*N-1:0] dt2);
    int         w;
    int         r_end;
    bit         ok;
    logic [N-1:0] oh;
    logic [7:0] et;
    logic [7:0] edt;
    w = rr_pick(r, ptr_m);
    if (w < 0) return;
    oh     = '0;
    oh[w]  = 1'b1;
    et     = t[8*w +: 8];
    edt    = dt[8*w +: 8];
    bus.req        = r;
    bus.T_in       = t;
    bus.dT_in      = dt;
    bus.core_valid = spur;
    bus.core_G     = ~g;
    @(negedge clk);  // launch cycle
    check_outputs("launch", oh, '0, '0, 1'b1);
    check("launch.core_T",  bus.core_T,  et);
    check("launch.core_dT", bus.core_dT, edt);
    bus.core_busy  = 1'b1;
    bus.core_valid = spur;
    if (scram) begin
      bus.req   = r2;
      bus.T_in  = t2;
      bus.dT_in = dt2;
    end
    @(negedge clk);  // first wait cycle
    bus.core_valid = 1'b0;
    ok    = (v <= TMO);
    r_end = ok ? v : TMO;
    for (int j = 1; j <= r_end; j++) begin
      check_outputs("wait", oh, '0, '0, 1'b0);
      check("wait.core_T",  bus.core_T,  et);
      check("wait.core_dT", bus.core_dT, edt);
      if (j == v) begin
        bus.core_valid = 1'b1;
        bus.core_G     = g;
      end
      @(negedge clk);
      bus.core_valid = 1'b0;
    end
    bus.core_busy = 1'b0;
    gres_m = ok ? g : 8'h00;
    check_outputs("resp", oh, ok ? oh : '0, ok ? '0 : oh, 1'b0);
    @(negedge clk);  // back in idle
    ptr_m = (w + 1) % N;
    check_outputs("after", '0, '0, '0, 1'b0);
    check("after.core_T", bus.core_T, et);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0]   r, r2;
    logic [8*N-1:0] t, dt, t2, dt2;
    int             v, sel;

    bus.req        = '0;
    bus.T_in       = '0;
    bus.dT_in      = '0;
    bus.core_busy  = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_G     = '0;

    do_reset(3);

    // All zones requesting from reset: service order 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      run_job(4'b1111, $urandom, $urandom, 1 + i % 3, 8'(10 + i), 1'b0, 1'b0, '0, '0, '0);

    // Single zone 2, T=0x40 dT=0x10, result 55 two cycles after start.
    idle(2);
    run_job(4'b0100, 32'h0040_0000, 32'h0010_0000, 2, 8'd55, 1'b0, 1'b0, '0, '0, '0);

    // Core silent: timeout with err and G_res=0, then next zone is served.
    run_job(4'b1111, $urandom, $urandom, TMO + 10, 8'd77, 1'b0, 1'b0, '0, '0, '0);
    run_job(4'b1111, $urandom, $urandom, 1, 8'd88, 1'b0, 1'b0, '0, '0, '0);

    // Result in the very last wait cycle wins; one cycle later is a timeout.
    run_job(4'b1111, $urandom, $urandom, TMO, 8'd99, 1'b0, 1'b0, '0, '0, '0);
    run_job(4'b1111, $urandom, $urandom, TMO + 1, 8'd42, 1'b0, 1'b0, '0, '0, '0);

    // Stray core_valid in idle and launch is ignored.
    run_job(4'b0001, $urandom, $urandom, 3, 8'd66, 1'b1, 1'b0, '0, '0, '0);

    // Zone 1 drops req and changes its operands after capture.
    run_job(4'b0010, 32'h0000_2100, 32'h0000_0500, 4, 8'd33, 1'b0, 1'b1,
            4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset during wait: no pulse, outputs cleared, arbitration restarts at 0.
    run_job(4'b0100, $urandom, $urandom, 1, 8'd12, 1'b0, 1'b0, '0, '0, '0);
    bus.req   = 4'b0010;
    bus.T_in  = $urandom;
    bus.dT_in = $urandom;
    @(negedge clk);
    check_outputs("rstjob.launch", 4'b0010, '0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 4'b1111;
    @(negedge clk);
    gres_m = 8'h00;
    check_reset_state("rst_in_wait");
    @(negedge clk);
    check_reset_state("rst_held");
    rst   = 1'b0;
    ptr_m = 0;
    run_job(4'b1111, $urandom, $urandom, 2, 8'd21, 1'b0, 1'b0, '0, '0, '0);

    // Randomized jobs.
    for (int i = 0; i < 120; i++) begin
      r   = N'($urandom_range(1, (1 << N) - 1));
      t   = $urandom;
      dt  = $urandom;
      r2  = N'($urandom);
      t2  = $urandom;
      dt2 = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      v = TMO + 1 + $urandom_range(0, 2);
      else if (sel == 1) v = TMO - $urandom_range(0, 1);
      else               v = $urandom_range(1, 12);
      run_job(r, t, dt, v, 8'($urandom_range(0, 100)),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), r2, t2, dt2);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
